// File: rtl/calc1_port_responder.sv
// ---------------------------------------------------------------------------
// calc1_port_responder
//
// Target side of the calc1 request/response protocol for a single port.
// A command arrives with operand 1; operand 2 follows on the next cycle.
// The result (add / sub / shift) is pushed into a fixed-depth response
// pipeline and appears on out_resp/out_data as a one-cycle pulse.
//
// Parameters
//   DATA_W   operand/result width (shift amount = low $clog2(DATA_W) bits
//            of operand 2)
//   LATENCY  response pipeline depth after the issue cycle, 1..8
//
// Ports
//   c_clk     in   1       clock, rising edge
//   reset_n   in   1       asynchronous active-low reset
//   cmd_in    in   4       0 none, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//   data_in   in   DATA_W  operand 1 on command cycle, operand 2 next cycle
//   out_resp  out  2       0 none, 1 success, 2 error
//   out_data  out  DATA_W  result while out_resp==1, else 0
//   busy      out  1       high while operand 2 is expected
//
// Build option
//   CALC1_SHIFT_EN  when defined, commands 5/6 execute as shifts; when
//                   undefined the shifter is not built and 5/6 are
//                   treated as invalid commands.
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for a command; invalid commands issue an error here
//   S_OP2  | operand 2 on data_in this cycle; result issued this cycle
// ---------------------------------------------------------------------------
module calc1_port_responder #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [3:0]        cmd_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [1:0]        out_resp,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int SHW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
`ifdef CALC1_SHIFT_EN
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;
`endif

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OP2  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   op1_q, op1_d;

  logic [1:0]          pipe_resp_q [LATENCY];
  logic [DATA_W-1:0]   pipe_data_q [LATENCY];

  logic                cmd_valid;
  logic [1:0]          push_resp;
  logic [DATA_W-1:0]   push_data;
  logic [1:0]          alu_resp;
  logic [DATA_W-1:0]   alu_data;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W-1:0]   diff_w;

  // Command decode: which opcodes start a two-cycle operation.
  always_comb begin
    cmd_valid = 1'b0;
    case (cmd_in)
      CMD_ADD: cmd_valid = 1'b1;
      CMD_SUB: cmd_valid = 1'b1;
`ifdef CALC1_SHIFT_EN
      CMD_SHL: cmd_valid = 1'b1;
      CMD_SHR: cmd_valid = 1'b1;
`endif
      default: cmd_valid = 1'b0;
    endcase
  end

  // Datapath: op1 is held in op1_q, op2 is taken live from data_in in S_OP2.
  assign sum_w  = {1'b0, op1_q} + {1'b0, data_in};
  assign diff_w = op1_q - data_in;

  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum_w[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = sum_w[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (data_in <= op1_q) begin
          alu_resp = RESP_OK;
          alu_data = diff_w;
        end
      end
`ifdef CALC1_SHIFT_EN
      // Only the low SHW bits of op2 form the shift amount.
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = op1_q << data_in[SHW-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = op1_q >> data_in[SHW-1:0];
      end
`endif
      default: begin
        alu_resp = RESP_ERR;
        alu_data = '0;
      end
    endcase
  end

  // Next-state and pipeline push. At most one entry is pushed per cycle.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    op1_d     = op1_q;
    push_resp = RESP_NONE;
    push_data = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_in != CMD_NONE) begin
          if (cmd_valid) begin
            cmd_d   = cmd_in;
            op1_d   = data_in;
            state_d = S_OP2;
          end else begin
            push_resp = RESP_ERR;
          end
        end
      end
      S_OP2: begin
        // cmd_in is ignored here; operand 2 is the only input of interest.
        push_resp = alu_resp;
        push_data = alu_data;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_NONE;
      op1_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
    end
  end

  // Response pipeline: an entry pushed in cycle N is on the outputs in N+LATENCY.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_resp_q[i] <= RESP_NONE;
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_resp_q[0] <= push_resp;
      pipe_data_q[0] <= push_data;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_resp_q[i] <= pipe_resp_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // Error and empty entries always carry zero data, so no output masking is needed.
  assign out_resp = pipe_resp_q[LATENCY-1];
  assign out_data = pipe_data_q[LATENCY-1];
  assign busy     = (state_q == S_OP2);

endmodule

// File: tb/tb_calc1_port_responder.sv
// ---------------------------------------------------------------------------
// tb_calc1_port_responder
//
// Directed bench for calc1_port_responder (DATA_W=32, LATENCY=3). Each
// sequence is a per-cycle table of drive values (cmd, data, reset) and
// hand-computed expected outputs (resp, data, busy) checked every cycle.
// Shift expectations follow the CALC1_SHIFT_EN build option.
// ---------------------------------------------------------------------------
module tb_calc1_port_responder;

  localparam int DATA_W = 32;
  localparam int LAT    = 3;
  localparam int MAXC   = 32;

  logic              c_clk;
  logic              reset_n;
  logic [3:0]        cmd_in;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  int total;
  int bad;

  logic [3:0]        drv_cmd  [MAXC];
  logic [DATA_W-1:0] drv_data [MAXC];
  logic              drv_rst  [MAXC];
  logic [1:0]        exp_resp [MAXC];
  logic [DATA_W-1:0] exp_data [MAXC];
  logic              exp_busy [MAXC];

  calc1_port_responder #(
    .DATA_W  (DATA_W),
    .LATENCY (LAT)
  ) dut (
    .c_clk    (c_clk),
    .reset_n  (reset_n),
    .cmd_in   (cmd_in),
    .data_in  (data_in),
    .out_resp (out_resp),
    .out_data (out_data),
    .busy     (busy)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic seq_clear();
    for (int i = 0; i < MAXC; i++) begin
      drv_cmd[i]  = 4'd0;
      drv_data[i] = '0;
      drv_rst[i]  = 1'b1;
      exp_resp[i] = 2'd0;
      exp_data[i] = '0;
      exp_busy[i] = 1'b0;
    end
  endtask

  // Two-cycle op issued at cycle c: response expected at c+1+LAT.
  task automatic put_op(input int c, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] r, input logic [31:0] d);
    drv_cmd[c]        = cmd;
    drv_data[c]       = a;
    drv_cmd[c+1]      = 4'd0;
    drv_data[c+1]     = b;
    exp_busy[c+1]     = 1'b1;
    exp_resp[c+1+LAT] = r;
    exp_data[c+1+LAT] = d;
  endtask

  // Invalid command at cycle c: error expected at c+LAT, no operand 2.
  task automatic put_inv(input int c, input logic [3:0] cmd, input logic [31:0] a);
    drv_cmd[c]      = cmd;
    drv_data[c]     = a;
    exp_resp[c+LAT] = 2'd2;
    exp_data[c+LAT] = '0;
  endtask

  task automatic run_seq(input string name, input int len);
    for (int c = 0; c < len; c++) begin
      chk($sformatf("%s resp c%0d", name, c), 32'(out_resp), 32'(exp_resp[c]));
      chk($sformatf("%s data c%0d", name, c), out_data, exp_data[c]);
      chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(exp_busy[c]));
      reset_n = drv_rst[c];
      cmd_in  = drv_cmd[c];
      data_in = drv_data[c];
      if (!drv_rst[c]) begin
        #1;
        chk($sformatf("%s rst resp c%0d", name, c), 32'(out_resp), 32'd0);
        chk($sformatf("%s rst busy c%0d", name, c), 32'(busy), 32'd0);
      end
      @(posedge c_clk);
      #1;
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    cmd_in  = 4'd0;
    data_in = '0;
    repeat (3) @(posedge c_clk);
    #1;
    chk("reset resp", 32'(out_resp), 32'd0);
    chk("reset data", out_data, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(posedge c_clk);
    #1;

    // Adds back-to-back every two cycles, including carry-out error and 0+0.
    seq_clear();
    put_op(0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
    put_op(2, 4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000);
    put_op(4, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000);
    put_op(6, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
    run_seq("add", 12);

    // Subtract: underflow, normal, equal operands.
    seq_clear();
    put_op(0, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000);
    put_op(2, 4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E);
    put_op(4, 4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0000_0000);
    run_seq("sub", 10);

    // Invalid command followed directly by an add; nonzero cmd during OP2 ignored.
    seq_clear();
    put_inv(0, 4'd3, 32'hDEAD_BEEF);
    put_op(1, 4'd1, 32'h0000_0005, 32'h0000_0006, 2'd1, 32'h0000_000B);
    drv_cmd[2] = 4'd3;
    put_inv(3, 4'd15, 32'h0000_0001);
    run_seq("inv", 9);

    // Shifts, or invalid-command errors when the shifter is not built.
    seq_clear();
`ifdef CALC1_SHIFT_EN
    put_op(0, 4'd5, 32'h0000_0001, 32'h0000_003F, 2'd1, 32'h8000_0000);
    put_op(2, 4'd6, 32'h8000_0000, 32'h0000_0004, 2'd1, 32'h0800_0000);
    put_op(4, 4'd5, 32'h0000_00F1, 32'h0000_0024, 2'd1, 32'h0000_0F10);
    run_seq("shift", 10);
`else
    put_inv(0, 4'd5, 32'h0000_0001);
    put_inv(2, 4'd6, 32'h8000_0000);
    run_seq("noshift", 7);
`endif

    // Reset one cycle after OP2: in-flight response discarded, then recovery.
    seq_clear();
    put_op(0, 4'd1, 32'h0000_0002, 32'h0000_0003, 2'd1, 32'h0000_0005);
    exp_resp[4] = 2'd0;
    exp_data[4] = '0;
    drv_rst[2]  = 1'b0;
    put_op(5, 4'd1, 32'h0000_0007, 32'h0000_0008, 2'd1, 32'h0000_000F);
    run_seq("rst", 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
